// File: rtl/seg_pkg.sv
// Shared constants, segment patterns and FSM states for the
// serial seven-segment link.
package seg_pkg;

  localparam int FRAME_BITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_OFF = SEG_BLANK[6:0];

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LATCH,
    HOLD,
    FLUSH
  } state_e;

endpackage

// File: rtl/seg_decode.sv
// Active-low segment frame to BCD digit, decimal point and
// undecodable-pattern flag.
module seg_decode
  import seg_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] digit,
  output logic       dp,
  output logic       err
);

  always_comb begin
    digit = 4'hF;
    err   = 1'b0;
    dp    = ~pattern[7];
    unique case (pattern[6:0])
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      SEG_OFF: digit = 4'hF;
      default: err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_stream_rx.sv
// Receive end of the serial seven-segment link: synchronise,
// deserialise, decode and store per-digit results.
module seg_stream_rx
  import seg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_clk,
  input  logic       seg_data,
  input  logic [3:0] dig_sel,
  input  logic       clear,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [3:0] dp,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       all_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] FB = 4'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] ck_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic [3:0]             sel_sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_sync_q  <= '0;
      dat_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++)
        sel_sync_q[i] <= 4'h0;
    end else begin
      ck_sync_q  <= {ck_sync_q[SYNC_STAGES-2:0], seg_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], seg_data};
      sel_sync_q[0] <= dig_sel;
      for (int i = 1; i < SYNC_STAGES; i++)
        sel_sync_q[i] <= sel_sync_q[i-1];
    end
  end

  logic       clk_s;
  logic       dat_s;
  logic [3:0] sel_s;
  logic       clk_prev_q;
  logic       rise;
  logic       sel_any;
  logic       sel_hot;

  assign clk_s   = ck_sync_q[SYNC_STAGES-1];
  assign dat_s   = dat_sync_q[SYNC_STAGES-1];
  assign sel_s   = sel_sync_q[SYNC_STAGES-1];
  assign rise    = clk_s & ~clk_prev_q;
  assign sel_any = |sel_s;
  assign sel_hot = $onehot(sel_s);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_inc;
  logic [7:0]    sr_q;
  logic [TW-1:0] tmo_q;
  logic          flush_arm_q;
  logic [3:0]    dig_q [4];
  logic [3:0]    dp_q;
  logic [3:0]    seen_q;
  logic          fv_q;
  logic          fe_q;

  logic [3:0] dec_digit;
  logic       dec_dp;
  logic       dec_err;

  seg_decode u_dec (
    .pattern (sr_q),
    .digit   (dec_digit),
    .dp      (dec_dp),
    .err     (dec_err)
  );

  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_q  <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= 4'h0;
      sr_q        <= 8'h00;
      tmo_q       <= '0;
      flush_arm_q <= 1'b0;
      dp_q        <= 4'h0;
      seen_q      <= 4'h0;
      fv_q        <= 1'b0;
      fe_q        <= 1'b0;
      for (int i = 0; i < 4; i++)
        dig_q[i] <= 4'hF;
    end else begin
      clk_prev_q <= clk_s;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!sel_any && rise) begin
            sr_q    <= {sr_q[6:0], dat_s};
            cnt_q   <= 4'd1;
            tmo_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (sel_any) begin
            if (cnt_q == FB) begin
              state_q <= LATCH;
            end else begin
              fe_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else if (rise) begin
            sr_q  <= {sr_q[6:0], dat_s};
            cnt_q <= cnt_inc;
            tmo_q <= '0;
            if (cnt_inc > FB) begin
              fe_q        <= 1'b1;
              flush_arm_q <= 1'b0;
              state_q     <= FLUSH;
            end
          end else if (tmo_q == TW'(TIMEOUT)) begin
            fe_q    <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        LATCH: begin
          if (!sel_hot) begin
            fe_q <= 1'b1;
          end else if (!clear) begin
            for (int i = 0; i < 4; i++) begin
              if (sel_s[i]) begin
                dig_q[i]  <= dec_digit;
                dp_q[i]   <= dec_dp;
                seen_q[i] <= 1'b1;
              end
            end
            fv_q <= 1'b1;
            fe_q <= dec_err;
          end
          state_q <= HOLD;
        end
        HOLD: begin
          if (!sel_any) state_q <= IDLE;
        end
        FLUSH: begin
          if (sel_any) flush_arm_q <= 1'b1;
          else if (flush_arm_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // clear takes priority over a same-cycle slot write
      if (clear) begin
        dp_q   <= 4'h0;
        seen_q <= 4'h0;
        for (int i = 0; i < 4; i++)
          dig_q[i] <= 4'hF;
      end
    end
  end

  assign digit1      = dig_q[0];
  assign digit2      = dig_q[1];
  assign digit3      = dig_q[2];
  assign digit4      = dig_q[3];
  assign dp          = dp_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign all_valid   = &seen_q;

endmodule

// File: tb/tb_seg_stream_rx.sv
// Randomised bench for seg_stream_rx with a frame-level
// reference model and per-cycle output comparison.
module tb_seg_stream_rx;

  localparam int TMO = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seg_clk = 1'b0;
  logic       seg_data = 1'b0;
  logic [3:0] dig_sel = 4'h0;
  logic       clear = 1'b0;
  logic [3:0] digit1, digit2, digit3, digit4;
  logic [3:0] dp;
  logic       frame_valid, frame_err, all_valid;

  always #5 clk = ~clk;

  seg_stream_rx #(.SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .seg_clk(seg_clk),
    .seg_data(seg_data), .dig_sel(dig_sel), .clear(clear),
    .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .digit4(digit4), .dp(dp), .frame_valid(frame_valid),
    .frame_err(frame_err), .all_valid(all_valid)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit       v;
    bit       e;
    int       slot;
    logic [3:0] d;
    bit       p;
  } ev_t;

  ev_t        evq[$];
  logic [3:0] m_dig [4];
  logic [3:0] m_dp;
  logic [3:0] m_seen;
  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] badsel [4] = '{4'b0011, 4'b0101, 4'b1111, 4'b1100};

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
    m_dp   = 4'h0;
    m_seen = 4'h0;
  endtask

  // Expected outcome of one frame from the link rules.
  task automatic expect_frame(input logic [7:0] f, input int n,
                              input logic [3:0] sel);
    ev_t ev;
    ev.v = 0; ev.e = 1; ev.slot = 0; ev.d = 4'hF; ev.p = 0;
    if (n == 8 && $countones(sel) == 1) begin
      ev.v = 1;
      ev.e = (f[6:0] != 7'h7F);
      for (int i = 0; i < 10; i++)
        if (pat[i] == f[6:0]) begin
          ev.d = 4'(i);
          ev.e = 0;
        end
      ev.p = ~f[7];
      for (int i = 0; i < 4; i++)
        if (sel[i]) ev.slot = i;
    end
    evq.push_back(ev);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [15:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      seg_data = b[i];
      tick($urandom_range(2, 4));
      seg_clk = 1'b1;
      tick($urandom_range(2, 4));
      seg_clk = 1'b0;
    end
  endtask

  task automatic strobe(input logic [3:0] sel);
    tick(4);
    dig_sel = sel;
    tick($urandom_range(5, 8));
    dig_sel = 4'h0;
    tick(8);
  endtask

  task automatic drain(input string nm);
    check({nm, "_pending"}, evq.size(), 0);
    evq.delete();
  endtask

  task automatic send(input logic [15:0] b, input int n,
                      input logic [3:0] sel, input string nm);
    expect_frame(b[7:0], n, sel);
    shift_bits(b, n);
    strobe(sel);
    drain(nm);
  endtask

  task automatic do_clear();
    tick(1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin : cmp
    ev_t ev;
    if (rst_n) begin
      if (frame_valid || frame_err) begin
        if (evq.size() == 0) begin
          check("unexpected_pulse", {frame_valid, frame_err}, 2'b00);
        end else begin
          ev = evq.pop_front();
          check("pulse", {frame_valid, frame_err}, {ev.v, ev.e});
          if (ev.v) begin
            m_dig[ev.slot]  = ev.d;
            m_dp[ev.slot]   = ev.p;
            m_seen[ev.slot] = 1'b1;
          end
        end
      end
      check("outputs",
            {digit4, digit3, digit2, digit1, dp, all_valid},
            {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_dp, &m_seen});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  initial begin
    logic [15:0] b;
    logic [3:0]  sel;
    int          n;
    int          k;
    model_reset();
    tick(3);
    check("rst_digits", {digit4, digit3, digit2, digit1}, 16'hFFFF);
    check("rst_flags", {dp, frame_valid, frame_err, all_valid}, 7'h0);
    rst_n = 1'b1;
    tick(3);

    send(16'h00B0, 8, 4'b0001, "t_digit3");
    check("t_digit3_lit", {digit1, dp[0]}, {4'd3, 1'b0});

    do_clear();
    send(16'h0040, 8, 4'b0010, "t4a");
    send(16'h0079, 8, 4'b0100, "t4b");
    send(16'h0024, 8, 4'b1000, "t4c");
    check("t4_not_all", all_valid, 1'b0);
    send(16'h00FF, 8, 4'b0001, "t4d");
    check("t4_lit", {digit1, digit2, digit3, digit4, all_valid},
          {4'hF, 4'd0, 4'd1, 4'd2, 1'b1});

    send(16'h0012, 7, 4'b0100, "t_short");
    check("t_short_lit", digit3, 4'd1);

    expect_frame(8'h00, 3, 4'b0000);
    shift_bits(16'h0005, 3);
    tick(TMO + 20);
    drain("t_timeout");
    send(16'h0012, 8, 4'b1000, "t_after_tmo");
    check("t_after_tmo_lit", {digit4, dp[3]}, {4'd5, 1'b1});

    send(16'h0055, 8, 4'b0001, "t_bad_pat");
    check("t_bad_pat_lit", digit1, 4'hF);

    send(16'h03C0, 10, 4'b0010, "t_long");
    send(16'h0030, 8, 4'b0011, "t_two_hot");
    check("t_two_hot_lit", all_valid, 1'b1);

    do_clear();
    check("clear_lit", {digit4, digit3, digit2, digit1, dp, all_valid},
          {16'hFFFF, 4'h0, 1'b0});

    send(16'h0079, 8, 4'b0001, "t_pre_rst");
    shift_bits(16'h000A, 4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    evq.delete();
    model_reset();
    #1;
    check("midrst_digits", {digit4, digit3, digit2, digit1}, 16'hFFFF);
    check("midrst_flags", {dp, frame_valid, frame_err, all_valid}, 7'h0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    send(16'h0002, 8, 4'b0100, "t_post_rst");
    check("t_post_rst_lit", {digit3, dp[2]}, {4'd6, 1'b1});

    repeat (60) begin
      k   = $urandom_range(0, 9);
      sel = 4'b0001 << $urandom_range(0, 3);
      n   = 8;
      b   = {8'($urandom), 1'($urandom_range(0, 1)),
             pat[$urandom_range(0, 9)]};
      if (k == 0) b[7:0] = 8'($urandom);
      if (k == 1) n = $urandom_range(1, 7);
      if (k == 2) n = $urandom_range(9, 12);
      if (k == 3) sel = badsel[$urandom_range(0, 3)];
      if (k == 4) b[6:0] = 7'h7F;
      send(b, n, sel, "rand");
    end

    tick(10);
    drain("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_stream_rx.md
Name: seg_stream_rx

Overview:
- Receive end of the serial seven-segment display link.
- Runs on the system clock and oversamples the display link: serial segment clock, serial segment data and the one-hot digit-select bus.
- Deserialises each 8-bit active-low segment frame, MSB first, and decodes the pattern back to a BCD digit and a decimal-point flag.
- Stores the result in the slot named by the one-hot digit select. Used as an on-chip display monitor and for loopback checking of the display driver.

Parameters:
- FRAME_BITS, 8, bits per segment frame; bit 7 = decimal point, bits 6..0 = segments g..a, active-low.
- SYNC_STAGES, 2, synchroniser flops on seg_clk, seg_data and dig_sel (minimum 2).
- TIMEOUT, 1024, system clocks allowed between seg_clk rising edges inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_clk  in  1  serial link clock; data is sampled on its rising edge
- seg_data  in  1  serial segment bit, MSB first
- dig_sel  in  4  one-hot digit latch strobe; 0 while a frame is shifting
- digit1..digit4  out  4 each  decoded digits; 4'hF = blank or undecodable
- dp  out  4  decimal-point flag per slot, active-high (dp[0] = digit1)
- frame_valid  out  1  one-cycle pulse when a slot is updated
- frame_err  out  1  one-cycle pulse on a bad frame
- all_valid  out  1  high once every slot has been updated since reset or clear
- clear  in  1  synchronous; resets slots and all_valid

Behaviour:
- Reset (rst_n low, asynchronous): digit1..4 = 4'hF, dp = 0, frame_valid = 0, frame_err = 0, all_valid = 0, state IDLE, bit count 0, shift register 0. Synchroniser flops also reset: seg_clk to 0, dig_sel to 0.
- Synchronisation: all three inputs pass through SYNC_STAGES flops. A seg_clk rising edge is detected one clock after the final sync stage. Input-to-sample latency is SYNC_STAGES+1 clocks.
- States:
  - IDLE: wait for a seg_clk edge while dig_sel_s == 0. The first edge shifts bit 1, count becomes 1, go to SHIFT.
  - SHIFT: each edge shifts in {sr[6:0], seg_data_s} and increments count. The timeout counter restarts on every edge.
    - dig_sel_s becomes nonzero with count == FRAME_BITS: go to LATCH.
    - dig_sel_s becomes nonzero with count != FRAME_BITS: frame_err, return to IDLE.
    - count exceeds FRAME_BITS: frame_err, go to FLUSH.
    - Timeout counter reaches TIMEOUT: frame_err, return to IDLE.
  - LATCH (1 clock): dig_sel_s must be exactly one-hot.
    - One-hot: decode and write the slot, pulse frame_valid, set that slot's seen bit, then go to HOLD.
    - Not one-hot: frame_err, no slot write, go to HOLD.
  - HOLD: wait for dig_sel_s == 0, then go to IDLE. seg_clk edges in HOLD are ignored.
  - FLUSH: wait for dig_sel_s nonzero then zero, discarding edges, then go to IDLE.
- Decode, pattern bits 6..0, active-low:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - 0x7F→F (blank), with no error.
  - Any other pattern→F plus frame_err; the slot is still written and frame_valid still pulses.
  - dp = ~sr[7].
- Slot mapping: dig_sel 0001→digit1, 0010→digit2, 0100→digit3, 1000→digit4.
- all_valid = AND of the four seen bits. clear zeroes the seen bits, sets digits to F and dp to 0.
- Simultaneous events:
  - clear wins over a LATCH write in the same cycle.
  - frame_valid and frame_err may both pulse in one cycle (undecodable pattern only).
- Wrap: the timeout counter saturates. The bit counter is 4 bits wide and saturates at 15.

Decomposition:
- Shared package seg_pkg holds:
  - constants FRAME_BITS and SEG_BLANK = 8'hFF;
  - the ten 7-bit segment pattern constants;
  - the state enum {IDLE, SHIFT, LATCH, HOLD, FLUSH}.
- One sub-module, seg_decode: combinational 8-bit pattern → {digit[3:0], dp, err}. The display driver reuses the same pattern constants so encoder and decoder stay consistent.

Test Plan:
- Send 8'b10110000 then dig_sel=0001 → digit1=3, dp[0]=0, one frame_valid pulse, no frame_err.
- Four frames 0x40, 0x79, 0x24, 0x7F (dp bit set, i.e. 0xFF for the blank) on 0010, 0100, 1000, 0001 → digit2=0, digit3=1, digit4=2, digit1=F; all_valid rises after the fourth frame.
- Send 7 bits, then dig_sel=0100 → frame_err pulse; digit3 unchanged; state returns to IDLE after dig_sel returns to 0.
- Send 3 bits, then stall for TIMEOUT+5 clocks → frame_err; the next good frame 0x12 on 1000 gives digit4=5.
- Send pattern 0x55 on 0001 → digit1=F, frame_valid and frame_err pulse in the same cycle.
- Assert rst_n low mid-frame at bit 4 → all outputs return to reset values immediately; assert clear with all_valid=1 → all_valid=0, digits F.
